// File: rtl/vga_core.sv
// vga_core: 640x480@60 Hz VGA timing generator with a colour-bar test pattern.
//
// Ports:
//   clock_25  in   25 MHz pixel clock, one pixel per rising edge
//   reset_key in   asynchronous active-high reset
//   vga_hs    out  horizontal sync, active low, registered
//   vga_vs    out  vertical sync, active low, registered
//   vga_r/g/b out  8-bit colour channels, decoded combinationally from the
//                  current counters (zero during blanking and during reset)
//
// pixel_x / pixel_y are the current beam position and are probed by name.
module vga_core #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clock_25,
    input  logic       reset_key,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);

    logic [9:0] pixel_x_q, pixel_x_d;
    logic [9:0] pixel_y_q, pixel_y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    assign pixel_x = pixel_x_q;
    assign pixel_y = pixel_y_q;

    // Counter advance; sync levels are derived from the *next* position so
    // the registered sync lines up with the counters in the same cycle.
    always_comb begin
        pixel_x_d = pixel_x_q + 10'd1;
        pixel_y_d = pixel_y_q;
        if (pixel_x_q == H_LAST) begin
            pixel_x_d = '0;
            if (pixel_y_q == V_LAST) begin
                pixel_y_d = '0;
            end else begin
                pixel_y_d = pixel_y_q + 10'd1;
            end
        end
        hs_d = !((pixel_x_d >= H_SYNC_BEG) && (pixel_x_d <= H_SYNC_END));
        vs_d = !((pixel_y_d >= V_SYNC_BEG) && (pixel_y_d <= V_SYNC_END));
    end

    always_ff @(posedge clock_25 or posedge reset_key) begin
        if (reset_key) begin
            pixel_x_q <= '0;
            pixel_y_q <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            pixel_x_q <= pixel_x_d;
            pixel_y_q <= pixel_y_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign vga_hs = hs_q;
    assign vga_vs = vs_q;

    // Pattern decode. Bar index is x/80, computed as x[9:4]/5.
    logic       video_on;
    logic       border;
    logic [5:0] bar_idx;
    logic [2:0] rgb;

    always_comb begin
        video_on = (pixel_x_q < H_ACT) && (pixel_y_q < V_ACT);
        border   = (pixel_x_q == '0) || (pixel_x_q == H_ACT_LAST) ||
                   (pixel_y_q == '0) || (pixel_y_q == V_ACT_LAST);
        bar_idx  = pixel_x_q[9:4] / 6'd5;
        rgb      = 3'b000;
        case (bar_idx)
            6'd0:    rgb = 3'b111; // white
            6'd1:    rgb = 3'b110; // yellow
            6'd2:    rgb = 3'b011; // cyan
            6'd3:    rgb = 3'b010; // green
            6'd4:    rgb = 3'b101; // magenta
            6'd5:    rgb = 3'b100; // red
            6'd6:    rgb = 3'b001; // blue
            default: rgb = 3'b000; // black
        endcase
        if (border) begin
            rgb = 3'b111;
        end
        // Reset gates the colour directly so the DAC sees black immediately.
        if (!video_on || reset_key) begin
            rgb = 3'b000;
        end
    end

    assign vga_r = {8{rgb[2]}};
    assign vga_g = {8{rgb[1]}};
    assign vga_b = {8{rgb[0]}};

endmodule

// File: tb/tb_vga_core.sv
// Testbench for vga_core. Two instances share the pixel clock: "dut" uses the
// full 640x480 timing, "dut_s" keeps the horizontal timing but shortens the
// vertical timing (8 active lines, 15 total) so whole frames fit in a short run.
module tb_vga_core;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic       hs_a, vs_a, hs_b, vs_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic [23:0] rgb_a, rgb_b;
    assign rgb_a = {r_a, g_a, b_a};
    assign rgb_b = {r_b, g_b, b_b};

    int errors = 0;
    int checks = 0;

    localparam int SV_ACT   = 8;
    localparam int SV_TOTAL = 15;
    localparam int SV_SBEG  = 10;
    localparam int SV_SEND  = 11;

    always #20 clk = ~clk;

    vga_core dut (
        .clock_25 (clk),
        .reset_key(rst_a),
        .vga_hs   (hs_a),
        .vga_vs   (vs_a),
        .vga_r    (r_a),
        .vga_g    (g_a),
        .vga_b    (b_a)
    );

    vga_core #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_s (
        .clock_25 (clk),
        .reset_key(rst_b),
        .vga_hs   (hs_b),
        .vga_vs   (vs_b),
        .vga_r    (r_b),
        .vga_g    (g_b),
        .vga_b    (b_b)
    );

    // Colour of each 80-pixel bar, left to right.
    logic [23:0] bar_colour [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] model_rgb(input int x, input int y, input int vact);
        if (x >= 640 || y >= vact) return 24'h000000;
        if (x == 0 || x == 639 || y == 0 || y == vact - 1) return 24'hFFFFFF;
        return bar_colour[x / 80];
    endfunction

    function automatic logic model_hs(input int x);
        return !(x >= 656 && x <= 751);
    endfunction

    // Waits (at falling edges) until the selected instance reaches (x,y).
    task automatic wait_xy(input bit sel, input int x, input int y, input int budget);
        int n;
        n = 0;
        while (1) begin
            if (!sel && dut.pixel_x == 10'(x) && dut.pixel_y == 10'(y)) return;
            if (sel && dut_s.pixel_x == 10'(x) && dut_s.pixel_y == 10'(y)) return;
            if (n >= budget) begin
                checks++; errors++;
                $display("FAIL wait_xy sel=%0d: (%0d,%0d) not reached within %0d cycles", sel, x, y, budget);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        int row, col;
        repeat (3) @(negedge clk);
        checks++; if ({dut.pixel_x, dut.pixel_y} !== 20'd0) begin errors++;
            $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", dut.pixel_x, dut.pixel_y); end
        checks++; if ({hs_a, vs_a} !== 2'b11) begin errors++;
            $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", hs_a, vs_a); end
        checks++; if (rgb_a !== 24'h0) begin errors++;
            $display("FAIL reset_rgb: got %h want 000000", rgb_a); end
        rst_a = 1'b0;
        #1;
        checks++; if (rgb_a !== 24'hFFFFFF) begin errors++;
            $display("FAIL release_rgb: got %h want ffffff", rgb_a); end
        @(posedge clk); #1;
        checks++; if (dut.pixel_x !== 10'd1) begin errors++;
            $display("FAIL first_edge_x: got %0d want 1", dut.pixel_x); end
        // Mid-line reset while hsync is low must act without a clock edge.
        row = $urandom_range(1, 3);
        col = 656 + $urandom_range(0, 90);
        wait_xy(0, col, row, 4000);
        checks++; if (hs_a !== 1'b0) begin errors++;
            $display("FAIL pre_reset_hs: got %b want 0 at x=%0d", hs_a, col); end
        #5 rst_a = 1'b1;
        #1;
        checks++; if ({dut.pixel_x, dut.pixel_y} !== 20'd0) begin errors++;
            $display("FAIL async_reset_pos: got (%0d,%0d) want (0,0)", dut.pixel_x, dut.pixel_y); end
        checks++; if ({hs_a, vs_a} !== 2'b11) begin errors++;
            $display("FAIL async_reset_sync: got hs=%b vs=%b want 1 1", hs_a, vs_a); end
        checks++; if (rgb_a !== 24'h0) begin errors++;
            $display("FAIL async_reset_rgb: got %h want 000000", rgb_a); end
    endtask

    task automatic test_line();
        int low, first, cnt_bad, rgb_bad;
        low = 0; first = -1; cnt_bad = 0; rgb_bad = 0;
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        for (int i = 0; i < 800; i++) begin
            if (dut.pixel_x !== 10'(i) || dut.pixel_y !== 10'd0) cnt_bad++;
            if (rgb_a !== model_rgb(i, 0, 480)) rgb_bad++;
            if (hs_a === 1'b0) begin
                if (low == 0) first = i;
                low++;
            end
            @(negedge clk);
        end
        checks++; if ({dut.pixel_x, dut.pixel_y} !== {10'd0, 10'd1}) begin errors++;
            $display("FAIL line_wrap: got (%0d,%0d) want (0,1)", dut.pixel_x, dut.pixel_y); end
        checks++; if (low !== 96) begin errors++;
            $display("FAIL hs_width: got %0d want 96", low); end
        checks++; if (first !== 656) begin errors++;
            $display("FAIL hs_start: got %0d want 656", first); end
        checks++; if (cnt_bad !== 0) begin errors++;
            $display("FAIL line_counter: %0d bad samples want 0", cnt_bad); end
        checks++; if (rgb_bad !== 0) begin errors++;
            $display("FAIL line_rgb: %0d bad pixels want 0", rgb_bad); end
    endtask

    task automatic test_colour_bars();
        int row;
        row = int'(dut.pixel_y) + 1;
        for (int k = 0; k < 8; k++) begin
            wait_xy(0, 40 + 80 * k, row, 1700);
            checks++; if (rgb_a !== bar_colour[k]) begin errors++;
                $display("FAIL bar%0d: got %h want %h", k, rgb_a, bar_colour[k]); end
        end
    endtask

    task automatic test_border_a();
        int row;
        row = int'(dut.pixel_y) + 1;
        wait_xy(0, 0, row, 1700);
        checks++; if (rgb_a !== 24'hFFFFFF) begin errors++;
            $display("FAIL border_left: got %h want ffffff", rgb_a); end
        wait_xy(0, 639, row, 1700);
        checks++; if (rgb_a !== 24'hFFFFFF) begin errors++;
            $display("FAIL border_right: got %h want ffffff", rgb_a); end
        @(negedge clk);
        checks++; if (rgb_a !== 24'h0) begin errors++;
            $display("FAIL hblank_640: got %h want 000000", rgb_a); end
    endtask

    task automatic test_random_points();
        int row, x;
        row = int'(dut.pixel_y) + 1;
        for (int k = 0; k < 6; k++) begin
            x = $urandom_range(0, 799);
            wait_xy(0, x, row + k, 1700);
            checks++; if (rgb_a !== model_rgb(x, row + k, 480)) begin errors++;
                $display("FAIL rand_rgb (%0d,%0d): got %h want %h", x, row + k, rgb_a, model_rgb(x, row + k, 480)); end
            checks++; if ({hs_a, vs_a} !== {model_hs(x), 1'b1}) begin errors++;
                $display("FAIL rand_sync (%0d,%0d): got hs=%b vs=%b want %b 1", x, row + k, hs_a, vs_a, model_hs(x)); end
        end
    endtask

    task automatic test_frame();
        int ex, ey, cnt_bad, rgb_bad, hs_bad, vs_bad, vs_low, fall1, fall2;
        logic prev_vs;
        cnt_bad = 0; rgb_bad = 0; hs_bad = 0; vs_bad = 0; vs_low = 0; fall1 = -1; fall2 = -1;
        @(negedge clk);
        checks++; if ({dut_s.pixel_x, dut_s.pixel_y, rgb_b} !== 44'd0) begin errors++;
            $display("FAIL held_reset: got (%0d,%0d) rgb=%h want (0,0) 000000", dut_s.pixel_x, dut_s.pixel_y, rgb_b); end
        rst_b = 1'b0;
        #1;
        prev_vs = 1'b1;
        for (int c = 0; c < 2 * 800 * SV_TOTAL; c++) begin
            ex = c % 800;
            ey = (c / 800) % SV_TOTAL;
            if (dut_s.pixel_x !== 10'(ex) || dut_s.pixel_y !== 10'(ey)) cnt_bad++;
            if (rgb_b !== model_rgb(ex, ey, SV_ACT)) rgb_bad++;
            if (hs_b !== model_hs(ex)) hs_bad++;
            if (vs_b !== !(ey >= SV_SBEG && ey <= SV_SEND)) vs_bad++;
            if (vs_b === 1'b0 && c < 800 * SV_TOTAL) vs_low++;
            if (prev_vs === 1'b1 && vs_b === 1'b0) begin
                if (fall1 < 0) fall1 = c; else if (fall2 < 0) fall2 = c;
            end
            prev_vs = vs_b;
            @(negedge clk);
        end
        checks++; if ({dut_s.pixel_x, dut_s.pixel_y} !== 20'd0) begin errors++;
            $display("FAIL frame_wrap: got (%0d,%0d) want (0,0)", dut_s.pixel_x, dut_s.pixel_y); end
        checks++; if (vs_low !== 1600) begin errors++;
            $display("FAIL vs_width: got %0d want 1600", vs_low); end
        checks++; if (fall1 !== SV_SBEG * 800) begin errors++;
            $display("FAIL vs_start: got %0d want %0d", fall1, SV_SBEG * 800); end
        checks++; if (fall2 - fall1 !== 800 * SV_TOTAL) begin errors++;
            $display("FAIL frame_period: got %0d want %0d", fall2 - fall1, 800 * SV_TOTAL); end
        checks++; if (cnt_bad !== 0) begin errors++;
            $display("FAIL frame_counter: %0d bad samples want 0", cnt_bad); end
        checks++; if (rgb_bad !== 0) begin errors++;
            $display("FAIL frame_image: %0d bad pixels want 0", rgb_bad); end
        checks++; if (hs_bad !== 0) begin errors++;
            $display("FAIL frame_hs: %0d bad samples want 0", hs_bad); end
        checks++; if (vs_bad !== 0) begin errors++;
            $display("FAIL frame_vs: %0d bad samples want 0", vs_bad); end
    endtask

    task automatic test_border_b();
        wait_xy(1, 600, 0, 13000);
        checks++; if (rgb_b !== 24'hFFFFFF) begin errors++;
            $display("FAIL border_top: got %h want ffffff", rgb_b); end
        wait_xy(1, 600, SV_ACT - 1, 13000);
        checks++; if (rgb_b !== 24'hFFFFFF) begin errors++;
            $display("FAIL border_bottom: got %h want ffffff", rgb_b); end
        wait_xy(1, 600, SV_ACT, 1700);
        checks++; if (rgb_b !== 24'h0) begin errors++;
            $display("FAIL vblank: got %h want 000000", rgb_b); end
    endtask

    task automatic test_vsync_reset();
        wait_xy(1, $urandom_range(0, 799), SV_SBEG + $urandom_range(0, 1), 13000);
        checks++; if (vs_b !== 1'b0) begin errors++;
            $display("FAIL pre_reset_vs: got %b want 0", vs_b); end
        #5 rst_b = 1'b1;
        #1;
        checks++; if ({vs_b, hs_b} !== 2'b11) begin errors++;
            $display("FAIL async_reset_vs: got vs=%b hs=%b want 1 1", vs_b, hs_b); end
        checks++; if ({dut_s.pixel_x, dut_s.pixel_y} !== 20'd0) begin errors++;
            $display("FAIL async_reset_pos_s: got (%0d,%0d) want (0,0)", dut_s.pixel_x, dut_s.pixel_y); end
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk); #1;
        checks++; if ({dut_s.pixel_x, dut_s.pixel_y} !== {10'd1, 10'd0}) begin errors++;
            $display("FAIL restart_s: got (%0d,%0d) want (1,0)", dut_s.pixel_x, dut_s.pixel_y); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_colour_bars();
        test_border_a();
        test_random_points();
        test_frame();
        test_border_b();
        test_vsync_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
